// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter joining the icache and dcache line ports onto one burst memory port.
// Each 256-bit line moves as four 64-bit beats, lowest beat first.
module l1_mem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic [31:0]           i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [31:0]           d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_address,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINE_WIDTH / 8);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] I_READ  = 3'd1;
    localparam logic [2:0] D_READ  = 3'd2;
    localparam logic [2:0] D_WRITE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]            state;
    logic [CW-1:0]         beat;
    logic [LINE_WIDTH-1:0] line_buf;
    logic                  rr_d;
    logic                  grant_d;
    logic                  i_req;
    logic                  d_req;
    logic                  pick_d;
    logic                  in_burst;
    logic                  unused_offset_bits;

    assign i_req    = i_pmem_read;
    assign d_req    = d_pmem_read | d_pmem_write;
    // rr_d set means the dcache wins a tie
    assign pick_d   = d_req & (~i_req | rr_d);
    assign in_burst = (state == I_READ) | (state == D_READ) | (state == D_WRITE);

    assign unused_offset_bits = ^{i_pmem_address[OFF-1:0], d_pmem_address[OFF-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            line_buf    <= '0;
            rr_d        <= 1'b0;
            grant_d     <= 1'b0;
            mem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        grant_d     <= pick_d;
                        mem_address <= pick_d ? {d_pmem_address[31:OFF], {OFF{1'b0}}}
                                              : {i_pmem_address[31:OFF], {OFF{1'b0}}};
                        if (!pick_d) begin
                            state <= I_READ;
                        end else if (d_pmem_write) begin
                            state    <= D_WRITE;
                            line_buf <= d_pmem_wdata;
                        end else begin
                            state <= D_READ;
                        end
                    end
                end
                I_READ, D_READ, D_WRITE: begin
                    if (mem_resp) begin
                        if (state != D_WRITE) begin
                            line_buf[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                        end
                        if (beat == CW'(BEATS - 1)) begin
                            beat  <= '0;
                            state <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    rr_d  <= ~rr_d;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read     = (state == I_READ) | (state == D_READ);
    assign mem_write    = (state == D_WRITE);
    assign mem_wdata    = (in_burst && mem_write) ? line_buf[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    assign i_pmem_resp  = (state == DONE) & ~grant_d;
    assign d_pmem_resp  = (state == DONE) & grant_d;
    assign i_pmem_rdata = line_buf;
    assign d_pmem_rdata = line_buf;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of round-robin arbitration and beat-ordered line transfer.
module tb_l1_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_pmem_read = 1'b0;
    logic [31:0]  i_pmem_address = '0;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read = 1'b0;
    logic         d_pmem_write = 1'b0;
    logic [31:0]  d_pmem_address = '0;
    logic [255:0] d_pmem_wdata = '0;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    bit pri_d = 1'b0;

    l1_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_mem_read"}, 256'(mem_read), 256'd0);
        check_output({tag, "_mem_write"}, 256'(mem_write), 256'd0);
        check_output({tag, "_mem_address"}, 256'(mem_address), 256'd0);
        check_output({tag, "_mem_wdata"}, 256'(mem_wdata), 256'd0);
        check_output({tag, "_i_resp"}, 256'(i_pmem_resp), 256'd0);
        check_output({tag, "_d_resp"}, 256'(d_pmem_resp), 256'd0);
        check_output({tag, "_i_rdata"}, i_pmem_rdata, 256'd0);
        check_output({tag, "_d_rdata"}, d_pmem_rdata, 256'd0);
    endtask

    // Serves one line transaction for the given side; stall < 0 means random 0..2 idle cycles per beat
    task automatic serve(input bit exp_d, input bit exp_wr, input logic [31:0] addr,
                         input logic [255:0] wline, input int stall, input bit use_fix,
                         input logic [255:0] fix_line);
        logic [255:0] rline;
        logic [63:0]  beat_val;
        int           wait_cycles;
        int           st;
        rline = '0;
        wait_cycles = 0;
        while (!(mem_read || mem_write) && wait_cycles < 8) begin
            step();
            wait_cycles++;
        end
        check_output("grant_latency", 256'(wait_cycles), 256'd1);
        for (int k = 0; k < 4; k++) begin
            st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int s = 0; s <= st; s++) begin
                check_output("burst_mem_read", 256'(mem_read), 256'(!exp_wr));
                check_output("burst_mem_write", 256'(mem_write), 256'(exp_wr));
                check_output("burst_mem_address", 256'(mem_address), 256'({addr[31:5], 5'b0}));
                if (exp_wr) check_output("burst_mem_wdata", 256'(mem_wdata), 256'(wline[64*k +: 64]));
                check_output("burst_no_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
                if (s == st) begin
                    beat_val = use_fix ? fix_line[64*k +: 64] : {$urandom, $urandom};
                    mem_rdata = beat_val;
                    rline[64*k +: 64] = beat_val;
                    mem_resp = 1'b1;
                end
                step();
                mem_resp = 1'b0;
            end
        end
        check_output("done_mem_read", 256'(mem_read), 256'd0);
        check_output("done_mem_write", 256'(mem_write), 256'd0);
        check_output("done_i_resp", 256'(i_pmem_resp), 256'(!exp_d));
        check_output("done_d_resp", 256'(d_pmem_resp), 256'(exp_d));
        if (!exp_wr) begin
            if (exp_d) check_output("done_d_rdata", d_pmem_rdata, rline);
            else       check_output("done_i_rdata", i_pmem_rdata, rline);
        end
        if (exp_d) begin
            d_pmem_read = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
        pri_d = ~pri_d;
        step();
        check_output("idle_no_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        check_output("idle_no_burst", 256'({mem_read, mem_write}), 256'd0);
    endtask

    // Reference arbitration: lone requester wins, a tie goes to the current priority side
    task automatic apply_stimulus(input int stall);
        bit req_i;
        bit req_d;
        bit exp_d;
        req_i = i_pmem_read;
        req_d = d_pmem_read | d_pmem_write;
        exp_d = (req_i && req_d) ? pri_d : req_d;
        serve(exp_d, exp_d && d_pmem_write, exp_d ? d_pmem_address : i_pmem_address,
              d_pmem_wdata, stall, 1'b0, '0);
    endtask

    initial begin
        logic [255:0] fix;
        logic [255:0] wl;
        int           pattern;

        #2;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Icache read alone with known beat data
        fix = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        i_pmem_address = 32'h0000_1234;
        i_pmem_read = 1'b1;
        serve(1'b0, 1'b0, 32'h0000_1234, '0, 0, 1'b1, fix);
        check_output("icache_line", i_pmem_rdata, fix);
        check_output("icache_addr", 256'(mem_address), 256'(32'h0000_1220));

        // Dcache writeback with a response every third cycle
        d_pmem_address = 32'hABCD_EF1F;
        d_pmem_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
        d_pmem_write = 1'b1;
        apply_stimulus(2);

        // Simultaneous reads: priority side first, then the other one
        i_pmem_address = 32'h0000_2000;
        d_pmem_address = 32'h0000_3000;
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        apply_stimulus(0);
        apply_stimulus(0);
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        apply_stimulus(1);
        apply_stimulus(1);

        // Read and write asserted together resolves to a writeback
        d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        d_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        apply_stimulus(0);

        // Stray mem_resp while idle must not advance the beat count
        mem_resp = 1'b1;
        step();
        step();
        mem_resp = 1'b0;
        check_output("stray_no_burst", 256'({mem_read, mem_write}), 256'd0);
        i_pmem_address = 32'h1234_5678;
        i_pmem_read = 1'b1;
        apply_stimulus(0);

        // Reset after the second beat aborts the burst
        i_pmem_address = 32'h0BAD_F00D;
        i_pmem_read = 1'b1;
        step();
        check_output("pre_reset_burst", 256'(mem_read), 256'd1);
        mem_resp = 1'b1;
        step();
        step();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        check_output("reset_hold_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        rst_n = 1'b1;
        pri_d = 1'b0;
        step();
        check_output("post_reset_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        i_pmem_address = 32'h0000_4444;
        i_pmem_read = 1'b1;
        apply_stimulus(0);

        // Randomized mixed traffic
        for (int t = 0; t < 24; t++) begin
            pattern = int'($urandom_range(0, 3));
            wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            i_pmem_address = $urandom;
            d_pmem_address = $urandom;
            d_pmem_wdata = wl;
            if (pattern != 1) i_pmem_read = 1'b1;
            if (pattern != 0) begin
                if ($urandom_range(0, 1) == 1) d_pmem_write = 1'b1;
                else d_pmem_read = 1'b1;
            end
            apply_stimulus(-1);
            if (pattern >= 2) apply_stimulus(-1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
